// File: rtl/rob_multiport.sv
// In-order reorder buffer: tail allocation, out-of-order multi-port writeback, single head commit.
// Optional store-to-load forwarding is built when ROB_STORE_FWD_EN is defined.
module rob_multiport #(
    parameter int SLOTS  = 16,
    parameter int IDX_W  = 4,
    parameter int NUM_WB = 5,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc_req,
    output logic                     alloc_ack,
    output logic [IDX_W-1:0]         alloc_idx,
    output logic                     full,
    output logic                     empty,
    output logic [IDX_W:0]           count,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]  wb_idx,
    input  logic [NUM_WB-1:0]        wb_except,
    input  logic [NUM_WB*DATA_W-1:0] wb_pc,
    input  logic [NUM_WB*DATA_W-1:0] wb_addr,
    input  logic [NUM_WB*DATA_W-1:0] wb_data,
    input  logic [NUM_WB*REG_W-1:0]  wb_dst,
    input  logic [NUM_WB-1:0]        wb_we,
    input  logic [NUM_WB-1:0]        wb_st,
    input  logic [NUM_WB-1:0]        wb_st_byte,
    input  logic                     rd_req,
    input  logic [DATA_W-1:0]        rd_addr,
    output logic                     rd_hit,
    output logic [DATA_W-1:0]        rd_data,
    output logic [DATA_W-1:0]        rd_addr_o,
    output logic                     rd_byte,
    output logic                     cm_valid,
    output logic                     cm_except,
    output logic [DATA_W-1:0]        cm_pc,
    output logic [DATA_W-1:0]        cm_addr,
    output logic [NUM_WB-1:0]        cm_type,
    output logic                     rf_we,
    output logic [REG_W-1:0]         rf_dst,
    output logic [DATA_W-1:0]        rf_data,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data,
    output logic                     mem_byte
);
    localparam int CNT_W = IDX_W + 1;

    logic [SLOTS-1:0]  r_alloc;
    logic [SLOTS-1:0]  r_done;
    logic [SLOTS-1:0]  r_except;
    logic [SLOTS-1:0]  r_we;
    logic [SLOTS-1:0]  r_st;
    logic [SLOTS-1:0]  r_st_byte;
    logic [DATA_W-1:0] r_pc   [SLOTS];
    logic [DATA_W-1:0] r_addr [SLOTS];
    logic [DATA_W-1:0] r_data [SLOTS];
    logic [REG_W-1:0]  r_dst  [SLOTS];
    logic [NUM_WB-1:0] r_type [SLOTS];
    logic [IDX_W-1:0]  r_head;
    logic [IDX_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [IDX_W-1:0]  w_wb_idx [NUM_WB];
    logic [NUM_WB-1:0] w_wb_hit;
    logic              w_cm_valid;
    logic              w_commit;
    logic              w_cm_flush;

    for (genvar k = 0; k < NUM_WB; k++) begin : g_wb
        assign w_wb_idx[k] = wb_idx[k*IDX_W +: IDX_W];
        assign w_wb_hit[k] = wb_valid[k] & r_alloc[w_wb_idx[k]];
    end

    assign full      = (r_count == CNT_W'(SLOTS));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign alloc_ack = alloc_req & ~full;
    assign alloc_idx = r_tail;

    assign w_cm_valid = r_alloc[r_head] & r_done[r_head];
    assign w_commit   = w_cm_valid & ~r_except[r_head];
    assign w_cm_flush = w_cm_valid & r_except[r_head];

    // Control state: a head exception clears the ROB exactly like an external flush.
    always_ff @(posedge clk) begin
        if (rst || flush || w_cm_flush) begin
            r_alloc <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (w_wb_hit[k]) r_done[w_wb_idx[k]] <= 1'b1;
            end
            if (w_commit) begin
                r_alloc[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + IDX_W'(1);
            end
            if (alloc_ack) begin
                r_alloc[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + IDX_W'(1);
            end
            r_count <= r_count + CNT_W'(alloc_ack) - CNT_W'(w_commit);
        end
    end

    // NOTE: payload is qualified by r_alloc/r_done, so it carries no reset and can map to plain storage.
    // Later ports overwrite earlier ones, giving the highest port priority on a slot collision.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_WB; k++) begin
            if (w_wb_hit[k]) begin
                r_except[w_wb_idx[k]]  <= wb_except[k];
                r_we[w_wb_idx[k]]      <= wb_we[k];
                r_st[w_wb_idx[k]]      <= wb_st[k];
                r_st_byte[w_wb_idx[k]] <= wb_st_byte[k];
                r_pc[w_wb_idx[k]]      <= wb_pc[k*DATA_W +: DATA_W];
                r_addr[w_wb_idx[k]]    <= wb_addr[k*DATA_W +: DATA_W];
                r_data[w_wb_idx[k]]    <= wb_data[k*DATA_W +: DATA_W];
                r_dst[w_wb_idx[k]]     <= wb_dst[k*REG_W +: REG_W];
                r_type[w_wb_idx[k]]    <= NUM_WB'(1) << k;
            end
        end
    end

    assign cm_valid  = w_cm_valid;
    assign cm_except = w_cm_flush;
    assign cm_pc     = w_cm_valid ? r_pc[r_head]   : '0;
    assign cm_addr   = w_cm_valid ? r_addr[r_head] : '0;
    assign cm_type   = w_cm_valid ? r_type[r_head] : '0;
    assign rf_we     = w_commit & r_we[r_head];
    assign rf_dst    = rf_we ? r_dst[r_head]  : '0;
    assign rf_data   = rf_we ? r_data[r_head] : '0;
    assign mem_we    = w_commit & r_st[r_head];
    assign mem_addr  = mem_we ? r_addr[r_head] : '0;
    assign mem_data  = mem_we ? r_data[r_head] : '0;
    assign mem_byte  = mem_we & r_st_byte[r_head];

`ifdef ROB_STORE_FWD_EN
    logic             w_fwd_hit;
    logic [IDX_W-1:0] w_fwd_idx;
    logic [IDX_W-1:0] w_scan;
    logic             w_unused_rd;

    // Walk oldest to youngest so the last match seen is the one closest to the tail.
    always_comb begin
        w_fwd_hit = 1'b0;
        w_fwd_idx = '0;
        w_scan    = '0;
        for (int i = 0; i < SLOTS; i++) begin
            // NOTE: blocking assignments here are intentional; each iteration reads the slot just computed.
            w_scan = r_head + IDX_W'(i);
            if (r_alloc[w_scan] && r_done[w_scan] && r_st[w_scan] && !r_except[w_scan] &&
                (r_addr[w_scan][DATA_W-1:2] == rd_addr[DATA_W-1:2])) begin
                w_fwd_hit = 1'b1;
                w_fwd_idx = w_scan;
            end
        end
    end

    assign rd_hit      = rd_req & w_fwd_hit;
    assign rd_data     = rd_hit ? r_data[w_fwd_idx] : '0;
    assign rd_addr_o   = rd_hit ? r_addr[w_fwd_idx] : '0;
    assign rd_byte     = rd_hit & r_st_byte[w_fwd_idx];
    assign w_unused_rd = ^rd_addr[1:0];
`else
    logic w_unused_rd;

    assign rd_hit      = 1'b0;
    assign rd_data     = '0;
    assign rd_addr_o   = '0;
    assign rd_byte     = 1'b0;
    assign w_unused_rd = ^{rd_req, rd_addr};
`endif

endmodule
